// File: rtl/fofir_pkg.sv
// Shared FoFIR PE constants and tap-loader state type, also used by the tap select mux.
package fofir_pkg;
  localparam int unsigned FOFIR_TAPS  = 11;
  localparam int unsigned FOFIR_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } tap_load_state_t;
endpackage

// File: rtl/fofir_tap_reg.sv
// Single tap word register with synchronous reset and load enable.
module fofir_tap_reg #(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [data_width-1:0] d,
  output logic [data_width-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/fofir_tap_demux11.sv
// Serial-to-parallel tap loader: streams 11 words (or single addressed writes)
// into the registered FIR tap bank.
module fofir_tap_demux11 #(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic                  wr_en,
  input  logic [3:0]            wr_sel,
  input  logic [data_width-1:0] wr_data,
  output logic [data_width-1:0] out0,
  output logic [data_width-1:0] out1,
  output logic [data_width-1:0] out2,
  output logic [data_width-1:0] out3,
  output logic [data_width-1:0] out4,
  output logic [data_width-1:0] out5,
  output logic [data_width-1:0] out6,
  output logic [data_width-1:0] out7,
  output logic [data_width-1:0] out8,
  output logic [data_width-1:0] out9,
  output logic [data_width-1:0] out10,
  output logic [10:0]           tap_valid,
  output logic [3:0]            cur_sel,
  output logic                  busy,
  output logic                  load_done,
  output logic                  wr_err
);
  import fofir_pkg::*;

  tap_load_state_t        state;
  logic [FOFIR_SEL_W-1:0] ptr;
  logic [FOFIR_TAPS-1:0]  tap_en;
  logic [data_width-1:0]  tap_q [FOFIR_TAPS];
  logic [data_width-1:0]  tap_d;
  logic                   load_hit;
  logic                   wr_idle;
  logic                   wr_in_range;
  logic                   wr_hit;
  logic                   ptr_last;

  // start takes priority over an addressed write in the same IDLE cycle
  assign load_hit    = (state == LOAD) && in_valid;
  assign wr_idle     = (state == IDLE) && wr_en && !start;
  assign wr_in_range = wr_sel < FOFIR_SEL_W'(FOFIR_TAPS);
  assign wr_hit      = wr_idle && wr_in_range;
  assign ptr_last    = ptr == FOFIR_SEL_W'(FOFIR_TAPS - 1);
  assign tap_d       = load_hit ? in_data : wr_data;

  for (genvar i = 0; i < FOFIR_TAPS; i++) begin : g_tap
    assign tap_en[i] = (load_hit && ptr == FOFIR_SEL_W'(i)) ||
                       (wr_hit && wr_sel == FOFIR_SEL_W'(i));

    fofir_tap_reg #(.data_width(data_width)) u_tap_reg (
      .clk (clk),
      .rst (rst),
      .en  (tap_en[i]),
      .d   (tap_d),
      .q   (tap_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tap_valid <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_idle && !wr_in_range;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            ptr       <= '0;
            tap_valid <= '0;
          end else begin
            tap_valid <= tap_valid | tap_en;
          end
        end
        LOAD: begin
          if (in_valid) begin
            tap_valid <= tap_valid | tap_en;
            if (ptr_last) begin
              state <= DONE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);
  assign cur_sel   = ptr;

  assign out0  = tap_q[0];
  assign out1  = tap_q[1];
  assign out2  = tap_q[2];
  assign out3  = tap_q[3];
  assign out4  = tap_q[4];
  assign out5  = tap_q[5];
  assign out6  = tap_q[6];
  assign out7  = tap_q[7];
  assign out8  = tap_q[8];
  assign out9  = tap_q[9];
  assign out10 = tap_q[10];
endmodule
